// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for the round-robin grant arbiter: FSM state encoding
// and a constant-width helper used to size the hold counter.
package rr_grant_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  // Bits needed to count 0..value-1; never narrower than one bit.
  function automatic int clog2_f(input int value);
    int width;
    width = 0;
    for (int v = 1; v < value; v = v << 1) begin
      width++;
    end
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_dec.sv
// Binary-to-one-hot decoder with an enable; outputs beyond the decoded
// range simply do not exist, so out-of-range indices yield all zeros.
module rr_grant_arbiter_dec #(
  parameter int INPUT_WIDTH  = 3,
  parameter int OUTPUT_WIDTH = 2**INPUT_WIDTH
) (
  input  logic [INPUT_WIDTH-1:0]  idx_i,
  input  logic                    en_i,
  output logic [OUTPUT_WIDTH-1:0] onehot_o
);

  for (genvar gi = 0; gi < OUTPUT_WIDTH; gi++) begin : g_bit
    assign onehot_o[gi] = en_i && (idx_i == INPUT_WIDTH'(gi));
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter granting exclusive ownership until the owner pulses
// done or the hold timer expires, then handing over with no idle gap.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
  parameter int INPUT_WIDTH = 3,
  parameter int NUM_REQ     = 2**INPUT_WIDTH,
  parameter int MAX_HOLD    = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic                   done,
  output logic [NUM_REQ-1:0]     grant,
  output logic [INPUT_WIDTH-1:0] grant_idx,
  output logic                   grant_vld,
  output logic                   timeout
);

  localparam int                    CNT_W     = clog2_f(MAX_HOLD);
  localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [INPUT_WIDTH-1:0] IDX_LAST  = INPUT_WIDTH'(NUM_REQ - 1);

  arb_state_e             state_q;
  logic [INPUT_WIDTH-1:0] rr_ptr_q;
  logic [INPUT_WIDTH-1:0] rr_ptr_d;
  logic [INPUT_WIDTH-1:0] grant_idx_q;
  logic [CNT_W-1:0]       hold_cnt_q;
  logic                   timeout_q;

  logic [NUM_REQ-1:0]     arb_req;
  logic                   found;
  logic [INPUT_WIDTH-1:0] winner;
  logic                   release_now;

  // First set bit at or above ptr; failing that, lowest set bit overall.
  function automatic logic [INPUT_WIDTH:0] find_winner(
    input logic [NUM_REQ-1:0]     r,
    input logic [INPUT_WIDTH-1:0] ptr
  );
    logic                   found_hi;
    logic                   found_any;
    logic [INPUT_WIDTH-1:0] idx_hi;
    logic [INPUT_WIDTH-1:0] idx_any;
    found_hi  = 1'b0;
    found_any = 1'b0;
    idx_hi    = '0;
    idx_any   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (r[k]) begin
        found_any = 1'b1;
        idx_any   = INPUT_WIDTH'(k);
        if (INPUT_WIDTH'(k) >= ptr) begin
          found_hi = 1'b1;
          idx_hi   = INPUT_WIDTH'(k);
        end
      end
    end
    if (found_hi) begin
      return {1'b1, idx_hi};
    end
    return {found_any, idx_any};
  endfunction

  // grant is zero in IDLE, so this only masks the owner while it is releasing.
  always_comb begin
    arb_req          = req & ~grant;
    {found, winner}  = find_winner(arb_req, rr_ptr_q);
    rr_ptr_d         = (winner == IDX_LAST) ? '0 : winner + 1'b1;
    release_now      = (state_q == ST_OWNED) && (done || (hold_cnt_q == HOLD_LAST));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (found) begin
            state_q     <= ST_OWNED;
            grant_idx_q <= winner;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= '0;
          end
        end
        ST_OWNED: begin
          if (release_now) begin
            // A done in the expiry cycle wins over the timeout.
            timeout_q  <= !done;
            hold_cnt_q <= '0;
            if (found) begin
              grant_idx_q <= winner;
              rr_ptr_q    <= rr_ptr_d;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign grant_vld = (state_q == ST_OWNED);
  assign grant_idx = grant_idx_q;
  assign timeout   = timeout_q;

  rr_grant_arbiter_dec #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .OUTPUT_WIDTH(NUM_REQ)
  ) u_grant_dec (
    .idx_i   (grant_idx_q),
    .en_i    (grant_vld),
    .onehot_o(grant)
  );

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench: an 8-requester arbiter with the default hold limit and a
// 5-requester arbiter with a short hold limit to exercise wrap and timeout.
module tb_rr_grant_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] a_req;
  logic       a_done;
  logic [7:0] a_grant;
  logic [2:0] a_idx;
  logic       a_vld;
  logic       a_to;
  logic [4:0] b_req;
  logic       b_done;
  logic [4:0] b_grant;
  logic [2:0] b_idx;
  logic       b_vld;
  logic       b_to;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_grant_arbiter #(
    .INPUT_WIDTH(3),
    .NUM_REQ    (8),
    .MAX_HOLD   (1024)
  ) dut_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (a_req),
    .done     (a_done),
    .grant    (a_grant),
    .grant_idx(a_idx),
    .grant_vld(a_vld),
    .timeout  (a_to)
  );

  rr_grant_arbiter #(
    .INPUT_WIDTH(3),
    .NUM_REQ    (5),
    .MAX_HOLD   (4)
  ) dut_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (b_req),
    .done     (b_done),
    .grant    (b_grant),
    .grant_idx(b_idx),
    .grant_vld(b_vld),
    .timeout  (b_to)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset_n = 1'b0;
    a_req   = '0;
    a_done  = 1'b0;
    b_req   = '0;
    b_done  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    $display("test_reset: requests and done held high during reset");
    reset_n = 1'b0;
    a_req   = 8'hFF;
    b_req   = 5'h1F;
    a_done  = 1'b1;
    tick();
    tick();
    checks++;
    if ({a_grant, a_idx, a_vld, a_to} !== 13'b0) begin
      errors++;
      $display("FAIL reset_a: got grant=%b idx=%0d vld=%b to=%b, want all zero", a_grant, a_idx, a_vld, a_to);
    end
    checks++;
    if ({b_grant, b_idx, b_vld, b_to} !== 10'b0) begin
      errors++;
      $display("FAIL reset_b: got grant=%b idx=%0d vld=%b to=%b, want all zero", b_grant, b_idx, b_vld, b_to);
    end
    reset_n = 1'b1;
    a_req   = '0;
    b_req   = '0;
    tick();
    a_done = 1'b0;
    checks++;
    if ({a_grant, a_idx, a_vld, a_to} !== 13'b0) begin
      errors++;
      $display("FAIL done_in_idle: got grant=%b idx=%0d vld=%b to=%b, want all zero", a_grant, a_idx, a_vld, a_to);
    end
  endtask

  task automatic test_single_grant;
    $display("test_single_grant: req=0000_0100 then release to idle");
    apply_reset();
    a_req = 8'b0000_0100;
    tick();
    checks++;
    if ({a_grant, a_idx, a_vld, a_to} !== {8'b0000_0100, 3'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL first_grant: got grant=%b idx=%0d vld=%b to=%b, want 00000100/2/1/0", a_grant, a_idx, a_vld, a_to);
    end
    a_req  = '0;
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    checks++;
    if ({a_grant, a_idx, a_vld, a_to} !== {8'h00, 3'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL release_idle: got grant=%b idx=%0d vld=%b to=%b, want 00000000/2/0/0", a_grant, a_idx, a_vld, a_to);
    end
  endtask

  task automatic test_round_robin;
    logic [7:0] exp_grant;
    logic [2:0] exp_idx;
    $display("test_round_robin: all requesting, done every third cycle");
    apply_reset();
    a_req = 8'hFF;
    tick();
    for (int n = 0; n < 9; n++) begin
      exp_idx   = 3'(n % 8);
      exp_grant = 8'd1 << exp_idx;
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({a_grant, a_idx, a_vld} !== {exp_grant, exp_idx, 1'b1}) begin
          errors++;
          $display("FAIL rr_order owner%0d cyc%0d: got grant=%b idx=%0d vld=%b, want %b/%0d/1", n, c, a_grant, a_idx, a_vld, exp_grant, exp_idx);
        end
        if (c == 2) a_done = 1'b1;
        tick();
        a_done = 1'b0;
      end
    end
  endtask

  task automatic test_timeout;
    int held;
    $display("test_timeout: owner 5 drops req and never signals done");
    apply_reset();
    a_req = 8'h20;
    tick();
    checks++;
    if ({a_grant, a_idx, a_vld} !== {8'h20, 3'd5, 1'b1}) begin
      errors++;
      $display("FAIL to_grant5: got grant=%b idx=%0d vld=%b, want 00100000/5/1", a_grant, a_idx, a_vld);
    end
    a_req = '0;
    held  = 0;
    for (int i = 1; i < 1024; i++) begin
      tick();
      if (a_vld && a_idx == 3'd5 && a_grant == 8'h20 && !a_to) held++;
    end
    checks++;
    if (held !== 1023) begin
      errors++;
      $display("FAIL to_hold: got %0d held cycles, want 1023", held);
    end
    tick();
    checks++;
    if ({a_grant, a_idx, a_vld, a_to} !== {8'h00, 3'd5, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL to_pulse: got grant=%b idx=%0d vld=%b to=%b, want 00000000/5/0/1", a_grant, a_idx, a_vld, a_to);
    end
    tick();
    checks++;
    if ({a_vld, a_to} !== 2'b00) begin
      errors++;
      $display("FAIL to_single: got vld=%b to=%b, want 0/0", a_vld, a_to);
    end
  endtask

  task automatic test_single_requester;
    int quiet;
    $display("test_single_requester: requester 3 held high, done and expiry coincide");
    apply_reset();
    a_req = 8'h08;
    tick();
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    checks++;
    if ({a_grant, a_idx, a_vld, a_to} !== {8'h00, 3'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sr_release: got grant=%b idx=%0d vld=%b to=%b, want 00000000/3/0/0", a_grant, a_idx, a_vld, a_to);
    end
    tick();
    checks++;
    if ({a_grant, a_idx, a_vld, a_to} !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sr_regrant: got grant=%b idx=%0d vld=%b to=%b, want 00001000/3/1/0", a_grant, a_idx, a_vld, a_to);
    end
    quiet = 0;
    for (int i = 1; i < 1024; i++) begin
      tick();
      if (a_vld && !a_to) quiet++;
    end
    checks++;
    if (quiet !== 1023) begin
      errors++;
      $display("FAIL sr_hold: got %0d quiet cycles, want 1023", quiet);
    end
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    checks++;
    if ({a_grant, a_vld, a_to} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL done_beats_timeout: got grant=%b vld=%b to=%b, want 00000000/0/0", a_grant, a_vld, a_to);
    end
    tick();
    checks++;
    if ({a_grant, a_idx, a_vld, a_to} !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sr_regrant2: got grant=%b idx=%0d vld=%b to=%b, want 00001000/3/1/0", a_grant, a_idx, a_vld, a_to);
    end
  endtask

  task automatic test_wrap_five;
    int held;
    $display("test_wrap_five: five requesters, pointer at 4 wraps to 0");
    apply_reset();
    b_req = 5'b01000;
    tick();
    checks++;
    if ({b_grant, b_idx, b_vld, b_to} !== {5'b01000, 3'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL w5_grant3: got grant=%b idx=%0d vld=%b to=%b, want 01000/3/1/0", b_grant, b_idx, b_vld, b_to);
    end
    b_req  = 5'b10001;
    b_done = 1'b1;
    tick();
    checks++;
    if ({b_grant, b_idx, b_vld, b_to} !== {5'b10000, 3'd4, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL w5_grant4: got grant=%b idx=%0d vld=%b to=%b, want 10000/4/1/0", b_grant, b_idx, b_vld, b_to);
    end
    tick();
    b_done = 1'b0;
    checks++;
    if ({b_grant, b_idx, b_vld, b_to} !== {5'b00001, 3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL w5_wrap0: got grant=%b idx=%0d vld=%b to=%b, want 00001/0/1/0", b_grant, b_idx, b_vld, b_to);
    end
    held = 0;
    for (int i = 1; i < 4; i++) begin
      tick();
      if (b_vld && b_idx == 3'd0 && !b_to) held++;
    end
    checks++;
    if (held !== 3) begin
      errors++;
      $display("FAIL w5_hold: got %0d held cycles, want 3", held);
    end
    tick();
    checks++;
    if ({b_grant, b_idx, b_vld, b_to} !== {5'b10000, 3'd4, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL w5_timeout_handover: got grant=%b idx=%0d vld=%b to=%b, want 10000/4/1/1", b_grant, b_idx, b_vld, b_to);
    end
    tick();
    checks++;
    if ({b_grant, b_idx, b_vld, b_to} !== {5'b10000, 3'd4, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL w5_after_timeout: got grant=%b idx=%0d vld=%b to=%b, want 10000/4/1/0", b_grant, b_idx, b_vld, b_to);
    end
    b_req = '0;
  endtask

  task automatic test_reset_mid_grant;
    $display("test_reset_mid_grant: reset while owned, pointer restarts at 0");
    apply_reset();
    a_req = 8'h04;
    tick();
    reset_n = 1'b0;
    a_req   = 8'hFF;
    tick();
    checks++;
    if ({a_grant, a_idx, a_vld, a_to} !== 13'b0) begin
      errors++;
      $display("FAIL mid_reset1: got grant=%b idx=%0d vld=%b to=%b, want all zero", a_grant, a_idx, a_vld, a_to);
    end
    reset_n = 1'b1;
    a_req   = 8'h84;
    tick();
    checks++;
    if ({a_grant, a_idx, a_vld, a_to} !== {8'h04, 3'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ptr_restart: got grant=%b idx=%0d vld=%b to=%b, want 00000100/2/1/0", a_grant, a_idx, a_vld, a_to);
    end
    reset_n = 1'b0;
    tick();
    checks++;
    if ({a_grant, a_idx, a_vld, a_to} !== 13'b0) begin
      errors++;
      $display("FAIL mid_reset2: got grant=%b idx=%0d vld=%b to=%b, want all zero", a_grant, a_idx, a_vld, a_to);
    end
    reset_n = 1'b1;
    a_req   = 8'h80;
    tick();
    checks++;
    if ({a_grant, a_idx, a_vld, a_to} !== {8'h80, 3'd7, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_7: got grant=%b idx=%0d vld=%b to=%b, want 10000000/7/1/0", a_grant, a_idx, a_vld, a_to);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    a_req   = '0;
    a_done  = 1'b0;
    b_req   = '0;
    b_done  = 1'b0;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_timeout();
    test_single_requester();
    test_wrap_five();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/rr_grant_arbiter.md
RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

Interface
REQ-001 Parameter SHALL be INPUT_WIDTH, default 3, index width.
REQ-002 Parameter SHALL be NUM_REQ, default 2**INPUT_WIDTH, requester count; must be ≤ 2**INPUT_WIDTH.
REQ-003 Parameter SHALL be MAX_HOLD, default 1024, grant-hold timeout in cycles; must be ≥ 2.
REQ-004 Port SHALL be clk  input  1  sole clock; all logic on rising edge.
REQ-005 Port SHALL be reset_n  input  1  synchronous, active-low reset.
REQ-006 Port SHALL be req  input  NUM_REQ  per-requester request level.
REQ-007 Port SHALL be done  input  1  single-cycle release pulse from current owner.
REQ-008 Port SHALL be grant  output  NUM_REQ  registered one-hot grant.
REQ-009 Port SHALL be grant_idx  output  INPUT_WIDTH  binary index of owner.
REQ-010 Port SHALL be grant_vld  output  1  high while any grant is held.
REQ-011 Port SHALL be timeout  output  1  single-cycle pulse on forced release.

Function
REQ-012 FSM SHALL have exactly two states: IDLE (no owner) and OWNED.
REQ-013 IDLE, any req bit set: next cycle -> OWNED with grant to the winner; latency 1 cycle from req to grant.
REQ-014 Winner SHALL be the first set req bit searching upward from rr_ptr and wrapping modulo NUM_REQ.
REQ-015 On each new grant, rr_ptr SHALL load (winner+1) mod NUM_REQ; wrap NUM_REQ-1 -> 0.
REQ-016 grant SHALL be the one-hot decode of grant_idx; grant bits at positions ≥ NUM_REQ SHALL never assert.
REQ-017 grant SHALL be zero and grant_vld low whenever state is IDLE; grant_idx holds its last value.
REQ-018 OWNED: grant SHALL hold unchanged regardless of req changes, including owner dropping req.
REQ-019 OWNED with done=1: release; if any req set (excluding owner's bit that cycle), re-arbitrate and grant next winner the following cycle with no IDLE gap; otherwise -> IDLE.
REQ-020 The owner's req bit SHALL be masked during the release cycle only, so a single requester with req held high regains the grant on the release cycle's successor.
REQ-021 Hold counter SHALL clear on every new grant and increment each OWNED cycle.
REQ-022 When hold counter reaches MAX_HOLD-1 without done, arbiter SHALL force release exactly as REQ-019 and pulse timeout for one cycle.
REQ-023 done and timeout coinciding SHALL be treated as done; timeout SHALL not pulse.
REQ-024 done in IDLE SHALL be ignored.
REQ-025 Hold counter width SHALL be clog2(MAX_HOLD); no overflow beyond MAX_HOLD-1.

Reset
REQ-026 reset_n low at a clock edge SHALL force IDLE, grant=0, grant_vld=0, grant_idx=0, timeout=0, rr_ptr=0, hold counter=0.
REQ-027 Reset asserted during OWNED SHALL drop grant at the next edge without timeout pulse; first post-reset arbitration starts at index 0.
REQ-028 req SHALL be ignored in any cycle where reset_n is low.

Structure
REQ-029 State encodings and clog2 helper SHALL reside in the shared utils include file, not locally.
REQ-030 One-hot grant generation SHALL instantiate the existing utils decoder (INPUT_WIDTH, OUTPUT_WIDTH=NUM_REQ) on the registered grant_idx, gated by grant_vld.
REQ-031 Winner search SHALL be a combinational function; all outputs SHALL be registered or derived from registers only.

Verification
REQ-032 Reset then req=8'b0000_0100 -> grant=8'b0000_0100, grant_idx=2, grant_vld=1 one cycle later.
REQ-033 req=8'hFF held, done every 3rd cycle -> grant order 0,1,2,...,7,0 with no IDLE cycle between owners.
REQ-034 Owner 5 granted, req drops to 0, no done -> grant holds; at MAX_HOLD cycles timeout pulses once, grant=0 next cycle.
REQ-035 Single requester 3 held high, done pulsed -> grant re-issued to 3 after release; done and timeout in same cycle -> timeout stays 0.
REQ-036 NUM_REQ=5, INPUT_WIDTH=3, req=5'b10001, ptr at 4 -> grants 4 then wrap to 0; grant bits 5–7 never set.
REQ-037 reset_n low mid-grant -> all outputs zero next edge; after release of reset with req=8'h80, grant_idx=7.
